// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the E stage (master) and the
// HI/LO multiply/divide unit (slave).
//   start   : one-cycle request strobe
//   md_op   : 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_val  : operand A (dividend / multiplicand / mthi-mtlo source)
//   rt_val  : operand B (divisor / multiplier)
//   busy    : operation in flight, D-stage hazard logic stalls on it
//   hi, lo  : architectural HI/LO registers
interface mult_div_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, rs_val, rt_val, input  busy, hi, lo);
  modport slave  (input  start, md_op, rs_val, rt_val, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: fixed-latency HI/LO responder for the E stage.
// The 64-bit result is computed combinationally at the accepting edge and
// parked in pending registers; a down-counter then models the multi-cycle
// latency, and HI/LO are committed on the edge the counter reaches zero.
// Ports:
//   clk   : clock
//   reset : synchronous, active-low reset
//   md    : mult_div_if.slave (start/md_op/rs_val/rt_val in, busy/hi/lo out)
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mult_div_if.slave md
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [63:0] pend_q;     // {hi, lo} to commit at completion
  logic        pend_wr_q;  // cleared for divide-by-zero: HI/LO untouched
  logic [31:0] hi_q, lo_q;

  logic        accept;
  logic        is_mul;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  logic [63:0] res_d;
  logic        wr_d;

  assign accept = md.start && (state_q == IDLE) &&
                  (md.md_op != 3'd0) && (md.md_op != 3'd7);
  assign is_mul = (md.md_op == OP_MULT) || (md.md_op == OP_MULTU);

  // Low 64 bits of a 64x64 product of sign-extended operands equal the
  // signed 32x32 product.
  assign prod_s = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
  assign prod_u = {32'd0, md.rs_val} * {32'd0, md.rt_val};

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // follows the dividend. 0x80000000 / -1 falls out naturally as 0x80000000
  // remainder 0, since the magnitude 0x80000000 round-trips through negation.
  assign a_neg  = (md.md_op == OP_DIV) && md.rs_val[31];
  assign b_neg  = (md.md_op == OP_DIV) && md.rt_val[31];
  assign a_mag  = a_neg ? -md.rs_val : md.rs_val;
  assign b_mag  = b_neg ? -md.rt_val : md.rt_val;
  assign b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;  // keep the divider defined
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem    = a_neg ? -r_mag : r_mag;

  always_comb begin
    res_d = 64'd0;
    wr_d  = 1'b1;
    case (md.md_op)
      OP_MULT:          res_d = prod_s;
      OP_MULTU:         res_d = prod_u;
      OP_DIV, OP_DIVU: begin
        res_d = {rem, quo};
        wr_d  = (md.rt_val != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (md.md_op == OP_MTHI)      hi_q <= md.rs_val;
            else if (md.md_op == OP_MTLO) lo_q <= md.rs_val;
            else begin
              pend_q    <= res_d;
              pend_wr_q <= wr_d;
              cnt_q     <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            if (pend_wr_q) begin
              hi_q <= pend_q[63:32];
              lo_q <= pend_q[31:0];
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy = (state_q == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mult_div_if bus();
  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md(bus.slave)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;   // busy samples seen before this response
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.hi = h; e.lo = l; e.cyc = c;
    sb.push_back(e);
  endtask

  // Drive one start pulse; returns at the first sample after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.start = 1'b0; bus.md_op = 3'd0;
  endtask

  // Wait for busy to drop, checking HI/LO hold their old values meanwhile.
  task automatic wait_idle(input string nm, input logic [31:0] h0, input logic [31:0] l0);
    int n = 0;
    while (bus.busy && n < 40) begin
      chk({nm, " hold"}, {bus.hi, bus.lo}, {h0, l0});
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, 64'(bus.busy), 64'd0);
  endtask

  // Monitor: a response is a busy falling edge, or a HI/LO change while idle.
  initial begin
    logic [63:0] prev = 64'd0;
    bit          bprev = 1'b0;
    int          run = 0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.busy) run++;
        else if (bprev || ({bus.hi, bus.lo} != prev)) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp actual=%h/%h expected=none", bus.hi, bus.lo);
          end else begin
            e = sb.pop_front();
            chk("resp_hi", 64'(bus.hi), 64'(e.hi));
            chk("resp_lo", 64'(bus.lo), 64'(e.lo));
            chk("resp_busy_cycles", 64'(run), 64'(e.cyc));
          end
          run = 0;
        end
      end else run = 0;
      prev  = {bus.hi, bus.lo};
      bprev = bus.busy;
    end
  end

  initial begin
    bus.start = 1'b1; bus.md_op = 3'd5; bus.rs_val = 32'h1234; bus.rt_val = 32'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    reset = 1'b1; bus.start = 1'b0; bus.md_op = 3'd0;
    mon_en = 1'b1;
    @(negedge clk);

    // mult -1 * 2, operands disturbed right after accept
    push(32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    wait_idle("mult", 32'd0, 32'd0);

    push(32'h00000001, 32'hFFFFFFFE, 5);
    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    wait_idle("multu", 32'hFFFFFFFF, 32'hFFFFFFFE);

    push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg", 32'h00000001, 32'hFFFFFFFE);

    push(32'hFFFFFFFF, 32'h000000AA, 0);
    issue(3'd6, 32'hAA, 32'd0);
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    push(32'h00000055, 32'h000000AA, 0);
    issue(3'd5, 32'h55, 32'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);

    // divu by zero: full busy window, HI/LO untouched
    push(32'h00000055, 32'h000000AA, 10);
    issue(3'd4, 32'd7, 32'd0);
    wait_idle("divu_zero", 32'h55, 32'hAA);

    push(32'h00000000, 32'h80000000, 10);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf", 32'h55, 32'hAA);

    // mult 3*5 with an mthi during RUN (ignored), another at the completion
    // edge (ignored) held one more edge (accepted)
    push(32'h00000000, 32'h0000000F, 5);
    push(32'h00000077, 32'h0000000F, 0);
    issue(3'd1, 32'd3, 32'd5);                      // busy sample 1
    @(negedge clk);                                 // sample 2
    bus.start = 1'b1; bus.md_op = 3'd5; bus.rs_val = 32'h99;
    @(negedge clk);                                 // sample 3
    bus.start = 1'b0; bus.md_op = 3'd0;
    @(negedge clk);                                 // sample 4
    chk("ignored_mthi_hi", 64'(bus.hi), 64'd0);
    @(negedge clk);                                 // sample 5
    chk("pre_completion_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b1; bus.md_op = 3'd5; bus.rs_val = 32'h77;
    @(negedge clk);                                 // completion edge passed
    chk("completion_start_ignored_hi", 64'(bus.hi), 64'd0);
    @(negedge clk);                                 // one edge later: accepted
    bus.start = 1'b0; bus.md_op = 3'd0;
    chk("late_mthi_hi", 64'(bus.hi), 64'h77);

    // reset at the 4th busy edge aborts div 100/3
    push(32'd0, 32'd0, 3);
    issue(3'd3, 32'd100, 32'd3);                    // sample 1
    @(negedge clk);                                 // sample 2
    @(negedge clk);                                 // sample 3
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    repeat (15) @(negedge clk);
    chk("abort_no_update", {bus.hi, bus.lo}, 64'd0);
    chk("abort_idle", 64'(bus.busy), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
